// File: rtl/axi_phase_sequencer.sv
// axi_phase_sequencer
// Steps an AXI channel test through NUM_PHASES phases. Each phase starts the
// write channels (AW/W/B), waits for all three done pulses, then starts the
// read channels (AR/R), waits for both, and clears the external done latches.
// A per-wait timer aborts the sequence into ERROR when TIMEOUT_CYCLES elapse.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   seq_start            single-cycle request to run a sequence (IDLE/ERROR only)
//   seq_abort            terminate a running sequence
//   phase_done[4:0]      done pulses: [0] AW, [1] W, [2] B, [3] AR, [4] R
//   phase_start[4:0]     start pulses, same bit mapping
//   clear_phase_latches  one-cycle clear of the channel done latches
//   phase_index[7:0]     current phase number
//   seq_busy             sequence in progress
//   seq_done             one-cycle pulse on normal completion
//   seq_error            sticky timeout flag
module axi_phase_sequencer #(
  parameter int unsigned NUM_PHASES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seq_start,
  input  logic       seq_abort,
  input  logic [4:0] phase_done,
  output logic [4:0] phase_start,
  output logic       clear_phase_latches,
  output logic [7:0] phase_index,
  output logic       seq_busy,
  output logic       seq_done,
  output logic       seq_error
);

  localparam int unsigned CH_W  = 5;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned TMR_W = 32;

  localparam logic [CH_W-1:0]  WR_MASK  = 5'b00111;
  localparam logic [CH_W-1:0]  RD_MASK  = 5'b11000;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam bit               TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE_START,
    S_WRITE_WAIT,
    S_READ_START,
    S_READ_WAIT,
    S_CLEAR,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  logic [CH_W-1:0]   done_seen;
  logic [TMR_W-1:0]  timer;

  logic [CH_W-1:0]   done_mask_c;
  logic [CH_W-1:0]   done_now_c;
  logic              wr_complete_c;
  logic              rd_complete_c;
  logic              timeout_hit_c;
  logic              active_c;

  // Only the channel group of the current half-phase may latch done pulses;
  // a pulse arriving this cycle counts toward completion.
  always_comb begin
    done_mask_c = '0;
    case (state)
      S_WRITE_START, S_WRITE_WAIT: done_mask_c = WR_MASK;
      S_READ_START,  S_READ_WAIT:  done_mask_c = RD_MASK;
      default:                     done_mask_c = '0;
    endcase
    done_now_c    = done_seen | (phase_done & done_mask_c);
    wr_complete_c = &done_now_c[2:0];
    rd_complete_c = &done_now_c[4:3];
    timeout_hit_c = TMO_EN && (timer == TMO_LAST);
    active_c      = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
  end

  // Sequencer state and registered outputs; abort beats completion beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      phase_start         <= '0;
      clear_phase_latches <= 1'b0;
      phase_index         <= '0;
      seq_busy            <= 1'b0;
      seq_done            <= 1'b0;
      seq_error           <= 1'b0;
      done_seen           <= '0;
      timer               <= '0;
    end else begin
      phase_start         <= '0;
      clear_phase_latches <= 1'b0;
      seq_done            <= 1'b0;

      if (seq_abort && active_c) begin
        state               <= S_IDLE;
        clear_phase_latches <= 1'b1;
        seq_busy            <= 1'b0;
        done_seen           <= '0;
        timer               <= '0;
      end else begin
        case (state)
          S_IDLE, S_ERROR: begin
            if (seq_start) begin
              state       <= S_WRITE_START;
              phase_start <= WR_MASK;
              phase_index <= '0;
              seq_busy    <= 1'b1;
              seq_error   <= 1'b0;
              done_seen   <= '0;
              timer       <= '0;
            end
          end

          S_WRITE_START: begin
            done_seen <= done_now_c;
            state     <= S_WRITE_WAIT;
          end

          S_WRITE_WAIT: begin
            done_seen <= done_now_c;
            if (wr_complete_c) begin
              state       <= S_READ_START;
              phase_start <= RD_MASK;
              timer       <= '0;
            end else if (timeout_hit_c) begin
              state               <= S_ERROR;
              seq_error           <= 1'b1;
              seq_busy            <= 1'b0;
              clear_phase_latches <= 1'b1;
              done_seen           <= '0;
              timer               <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end

          S_READ_START: begin
            done_seen <= done_now_c;
            state     <= S_READ_WAIT;
          end

          S_READ_WAIT: begin
            done_seen <= done_now_c;
            if (rd_complete_c) begin
              state               <= S_CLEAR;
              clear_phase_latches <= 1'b1;
              done_seen           <= '0;
            end else if (timeout_hit_c) begin
              state               <= S_ERROR;
              seq_error           <= 1'b1;
              seq_busy            <= 1'b0;
              clear_phase_latches <= 1'b1;
              done_seen           <= '0;
              timer               <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end

          S_CLEAR: begin
            if (phase_index == LAST_IDX) begin
              state    <= S_DONE;
              seq_done <= 1'b1;
              seq_busy <= 1'b0;
            end else begin
              state       <= S_WRITE_START;
              phase_start <= WR_MASK;
              phase_index <= phase_index + IDX_W'(1);
              timer       <= '0;
            end
          end

          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_phase_sequencer.sv
// Bench for axi_phase_sequencer: plans each sequence ahead of time from
// randomly chosen channel done delays, derives the expected output events by
// arithmetic, and lets a monitor compare every cycle against that queue.
module tb_axi_phase_sequencer;

  localparam int NP   = 2;
  localparam int TO   = 20;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       seq_start;
  logic       seq_abort;
  logic [4:0] phase_done;
  logic [4:0] phase_start;
  logic       clear_phase_latches;
  logic [7:0] phase_index;
  logic       seq_busy;
  logic       seq_done;
  logic       seq_error;

  axi_phase_sequencer #(
    .NUM_PHASES    (NP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .seq_start          (seq_start),
    .seq_abort          (seq_abort),
    .phase_done         (phase_done),
    .phase_start        (phase_start),
    .clear_phase_latches(clear_phase_latches),
    .phase_index        (phase_index),
    .seq_busy           (seq_busy),
    .seq_done           (seq_done),
    .seq_error          (seq_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] ps;
    logic       clr;
    logic       dn;
    logic       busy;
    logic       err;
    logic [7:0] idx;
  } exp_t;

  exp_t     exp_q[$];
  exp_t     mon_e;
  bit [4:0] done_sched [MAXC];
  bit       start_sched[MAXC];
  bit       abort_sched[MAXC];
  bit       rst_sched  [MAXC];
  int       cyc       = 0;
  int       sched_max = 0;
  int       n_checks  = 0;
  int       n_fail    = 0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Mostly short delays, occasionally exactly at / one past the timeout limit.
  function automatic int pick_d();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return TO;
    if (r == 1) return TO + 1;
    return int'($urandom_range(0, 6));
  endfunction

  task automatic push_ev(input int c, input logic [4:0] ps, input logic clr,
                         input logic dn, input logic busy, input logic err,
                         input logic [7:0] idx);
    exp_t e;
    e.cyc = c; e.ps = ps; e.clr = clr; e.dn = dn;
    e.busy = busy; e.err = err; e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic sched_done(input int c, input logic [4:0] bits);
    if (c < MAXC) begin
      done_sched[c] = done_sched[c] | bits;
      if (c > sched_max) sched_max = c;
    end
  endtask

  // Modes: 0 random, 1 abort in phase-1 write wait, 2 reset in read wait,
  // 3 staggered write dones with a stray read done, 4 read channel R withheld,
  // 5 every done 5 cycles after its start.
  task automatic plan_seq(input int s, input int mode, output int last);
    int         t;
    int         rs;
    int         cl;
    int         dmax;
    int         d[5];
    logic [7:0] ix;
    start_sched[s] = 1'b1;
    t    = s + 1;
    last = t;
    for (int p = 0; p < NP; p++) begin
      ix = 8'(p);
      push_ev(t, 5'b00111, 1'b0, 1'b0, 1'b1, 1'b0, ix);
      for (int k = 0; k < 3; k++) d[k] = (mode == 5) ? 5 : pick_d();
      if (mode == 3 && p == 0) begin
        d[0] = 5; d[1] = 5; d[2] = 2;
        sched_done(t + 3, 5'b10000);
      end
      if (mode == 1 && p == 1) begin
        abort_sched[t + 1] = 1'b1;
        start_sched[t + 1] = 1'b1;
        for (int k = 0; k < 3; k++) sched_done(t + d[k], 5'(1 << k));
        push_ev(t + 2, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, ix);
        push_ev(t + 3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, ix);
        last = t + 3;
        return;
      end
      if (mode == 3 || $urandom_range(0, 2) == 0) start_sched[t + 1] = 1'b1;
      for (int k = 0; k < 3; k++)
        if (d[k] <= 2 * TO) sched_done(t + d[k], 5'(1 << k));
      dmax = imax(imax(d[0], d[1]), d[2]);
      if (dmax > TO) begin
        push_ev(t + TO + 1, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, ix);
        push_ev(t + TO + 2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, ix);
        last = t + TO + 2;
        return;
      end
      rs = t + imax(dmax, 1) + 1;
      for (int c = t; c < rs; c++)
        if ($urandom_range(0, 3) == 0) sched_done(c, 5'($urandom_range(1, 3)) << 3);
      push_ev(rs, 5'b11000, 1'b0, 1'b0, 1'b1, 1'b0, ix);

      d[3] = (mode == 5) ? 5 : pick_d();
      d[4] = (mode == 5) ? 5 : pick_d();
      if (mode == 4 && p == 0) d[4] = 1000;
      if (mode == 2 && p == 0) begin
        d[3] = int'($urandom_range(3, 6));
        d[4] = int'($urandom_range(3, 6));
        rst_sched[rs + 1] = 1'b1;
        sched_done(rs + d[3], 5'b01000);
        sched_done(rs + d[4], 5'b10000);
        push_ev(rs + 2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        push_ev(rs + 3, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        last = rs + 3;
        return;
      end
      if (d[3] <= 2 * TO) sched_done(rs + d[3], 5'b01000);
      if (d[4] <= 2 * TO) sched_done(rs + d[4], 5'b10000);
      dmax = imax(d[3], d[4]);
      if (dmax > TO) begin
        push_ev(rs + TO + 1, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, ix);
        push_ev(rs + TO + 2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, ix);
        last = rs + TO + 2;
        return;
      end
      cl = rs + imax(dmax, 1) + 1;
      for (int c = rs; c < cl; c++)
        if ($urandom_range(0, 3) == 0) sched_done(c, 5'($urandom_range(1, 7)));
      push_ev(cl, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, ix);
      if (p == NP - 1) begin
        push_ev(cl + 1, 5'b00000, 1'b0, 1'b1, 1'b0, 1'b0, ix);
        push_ev(cl + 2, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, ix);
        last = cl + 2;
        return;
      end
      t = cl + 1;
    end
  endtask

  // Driver: inputs for cycle N are applied just after clock edge N.
  initial begin
    rst        = 1'b1;
    seq_start  = 1'b0;
    seq_abort  = 1'b0;
    phase_done = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc < MAXC) begin
        rst        = (cyc < 3) || rst_sched[cyc];
        seq_start  = start_sched[cyc];
        seq_abort  = abort_sched[cyc];
        phase_done = done_sched[cyc];
      end else begin
        rst = 1'b0; seq_start = 1'b0; seq_abort = 1'b0; phase_done = '0;
      end
    end
  end

  // Monitor: compares expected events on their cycle, flags any other activity.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL stale_event cyc=%0d: expected event for cycle %0d was never compared",
                 cyc, mon_e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        n_checks++;
        if ({phase_start, clear_phase_latches, seq_done, seq_busy, seq_error, phase_index} !==
            {mon_e.ps, mon_e.clr, mon_e.dn, mon_e.busy, mon_e.err, mon_e.idx}) begin
          n_fail++;
          $display("FAIL event cyc=%0d: got ps=%h clr=%b done=%b busy=%b err=%b idx=%0d, want ps=%h clr=%b done=%b busy=%b err=%b idx=%0d",
                   cyc, phase_start, clear_phase_latches, seq_done, seq_busy, seq_error, phase_index,
                   mon_e.ps, mon_e.clr, mon_e.dn, mon_e.busy, mon_e.err, mon_e.idx);
        end
      end else begin
        n_checks++;
        if (phase_start !== 5'b00000 || clear_phase_latches !== 1'b0 || seq_done !== 1'b0) begin
          n_fail++;
          $display("FAIL unexpected_activity cyc=%0d: got ps=%h clr=%b done=%b, want all 0",
                   cyc, phase_start, clear_phase_latches, seq_done);
        end
      end
    end
  end

  initial begin
    int s;
    int last;
    int mode;
    for (int c = 2; c <= 4; c++) push_ev(c, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    s = 8;
    for (int it = 0; it < 40; it++) begin
      case (it)
        0:       mode = 5;
        1:       mode = 3;
        2:       mode = 4;
        3:       mode = 0;
        4:       mode = 1;
        5:       mode = 0;
        6:       mode = 2;
        7:       mode = 0;
        default: mode = 0;
      endcase
      if (s + 300 >= MAXC) break;
      while (cyc < s - 1) @(negedge clk);
      plan_seq(s, mode, last);
      s = imax(last, sched_max) + 3 + int'($urandom_range(0, 3));
    end
    while (cyc < s) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d uncompared events, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_phase_sequencer.md
AXI_PHASE_SEQUENCER -- requirements
Module: axi_phase_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PHASES, default 4, giving the test phases per sequence (legal 1..256).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, giving the maximum wait cycles per group (0 = timeout disabled).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
REQ-004 The block SHALL have the following remaining ports:
- seq_start  in  1  single-cycle request to run a sequence.
- seq_abort  in  1  request to terminate the running sequence.
- phase_done  in  5  per-channel done pulses: [0] write addr, [1] write data, [2] write resp, [3] read addr, [4] read data.
- phase_start  out  5  per-channel start pulses, same bit mapping.
- clear_phase_latches  out  1  one-cycle pulse that clears the channel done latches.
- phase_index  out  8  current test phase number.
- seq_busy  out  1  sequence in progress.
- seq_done  out  1  one-cycle pulse on normal completion.
- seq_error  out  1  sticky timeout flag.

Function
REQ-005 All outputs SHALL be registered.
REQ-006 States SHALL be IDLE, WRITE_START, WRITE_WAIT, READ_START, READ_WAIT, CLEAR, DONE and ERROR.
REQ-007 In IDLE or ERROR, a sampled seq_start SHALL do all of the following on the next cycle: move to WRITE_START, set phase_index=0, set seq_busy=1, clear seq_error.
REQ-008 In WRITE_START, phase_start SHALL equal 5'b00111 for exactly one cycle; the next state SHALL be WRITE_WAIT.
REQ-009 In READ_START, phase_start SHALL equal 5'b11000 for exactly one cycle; the next state SHALL be READ_WAIT.
REQ-010 phase_start SHALL be 0 in every other state.
REQ-011 Internal sticky done_seen[4:0] SHALL behave as follows:
- bits [2:0] set by phase_done only in WRITE_START/WRITE_WAIT;
- bits [4:3] set by phase_done only in READ_START/READ_WAIT;
- done pulses in any other state are ignored.
REQ-012 WRITE_WAIT SHALL exit to READ_START in the cycle after done_seen[2:0] is complete, counting a pulse arriving in the current cycle; done pulses may arrive in any order or simultaneously.
REQ-013 READ_WAIT SHALL exit to CLEAR in the cycle after done_seen[4:3] is complete, under the same rule as REQ-012.
REQ-014 In CLEAR, clear_phase_latches SHALL be 1 for one cycle and done_seen SHALL be zeroed.
REQ-015 From CLEAR, if phase_index==NUM_PHASES-1 the next state SHALL be DONE; otherwise phase_index SHALL increment by 1 and the next state SHALL be WRITE_START.
REQ-016 DONE SHALL pulse seq_done for one cycle, drop seq_busy and return to IDLE.
REQ-017 A 32-bit wait timer SHALL behave as follows:
- zeroed on entry to each START state;
- increments every cycle in the WAIT states.
REQ-018 When the timer reaches TIMEOUT_CYCLES-1 in a WAIT state without completion, and TIMEOUT_CYCLES is not 0, the next state SHALL be ERROR; in that transition seq_error=1, seq_busy=0 and clear_phase_latches SHALL pulse once.
REQ-019 If completion and timeout occur in the same cycle, completion SHALL win.
REQ-020 seq_abort in any state other than IDLE, DONE or ERROR SHALL cause all of the following on the next cycle: one clear_phase_latches pulse, state IDLE, seq_busy=0, no seq_done, seq_error unchanged.
REQ-021 Priority SHALL be rst > seq_abort > completion > timeout.
REQ-022 seq_start SHALL be ignored while seq_busy=1, including when it coincides with seq_abort.

Reset
REQ-023 On rst=1 the block SHALL, at the clock edge:
- set state to IDLE;
- set phase_start=0, clear_phase_latches=0, phase_index=0, seq_busy=0, seq_done=0, seq_error=0;
- zero done_seen and the timer.
REQ-024 Reset mid-sequence SHALL take effect at the next edge, with no clear_phase_latches pulse and no seq_done.

Verification
REQ-025 NUM_PHASES=2; each channel pulses done 5 cycles after its start -> phase_start shows 0x07, 0x18, 0x07, 0x18; two clear_phase_latches pulses; phase_index 0 then 1; one seq_done pulse; seq_busy then 0.
REQ-026 Write dones arrive as [2] alone, then [0] and [1] together 3 cycles later -> READ_START occurs exactly 1 cycle after the last done; a stray phase_done[4] during WRITE_WAIT is ignored.
REQ-027 TIMEOUT_CYCLES=20; phase_done[4] is withheld -> seq_error=1 after 20 READ_WAIT cycles; one clear pulse; seq_busy=0; a later seq_start clears seq_error and restarts at phase_index=0.
REQ-028 seq_abort in WRITE_WAIT of phase 1 -> next cycle clear_phase_latches=1, state IDLE, no seq_done; then seq_start runs a full sequence.
REQ-029 rst asserted in READ_WAIT -> next edge gives all outputs 0; a subsequent phase_done pulse causes no activity.
REQ-030 seq_start pulsed during WRITE_WAIT -> no effect on phase_index or phase_start.
